edit_block_ctrl: RTL and testbench

Sequencer for the handwriting editor's block cursor. Converts mouse clicks and key pulses into the `editing` flag and `writing_block_pos` consumed by the pixel generator. Handshakes with the drawing canvas (clear before each new block) and the word store (commit a finished block). Advances the cursor across the 20x15 grid of 32x32-pixel blocks.

---
 rtl/edit_block_ctrl.sv | 172 +++++++++++++++++
 tb/tb_edit_block_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/edit_block_ctrl.sv
// Block-cursor sequencer for the handwriting editor.
// Turns clicks and key pulses into the editing flag and active block position,
// handshakes with the canvas (clear) and the word store (write), and steps the
// cursor across the block grid after each committed block.
module edit_block_ctrl #(
  parameter int GRID_W      = 20,
  parameter int GRID_H      = 15,
  parameter int ACK_TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mouse_click,
  input  logic [9:0] MOUSE_X_POS,
  input  logic [8:0] MOUSE_Y_POS,
  input  logic       key_commit,
  input  logic       key_cancel,
  input  logic       canvas_clear_ack,
  input  logic       word_wr_ack,
  output logic       editing,
  output logic [8:0] writing_block_pos,
  output logic       canvas_clear_req,
  output logic       word_wr_req,
  output logic [8:0] word_wr_addr,
  output logic       timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_EDIT,
    S_WRITE,
    S_ADVANCE
  } state_e;

  localparam int               CNT_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [4:0]       X_LAST   = 5'(GRID_W - 1);
  localparam logic [3:0]       Y_LAST   = 4'(GRID_H - 1);
  // The last waiting cycle before giving up; the counter starts at 0.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [4:0]       x_q, x_d;
  logic [3:0]       y_q, y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_d;

  logic             editing_q, editing_d;
  logic             clear_req_q, clear_req_d;
  logic             wr_req_q, wr_req_d;
  logic [8:0]       wr_addr_q, wr_addr_d;
  logic             timeout_err_q;

  // Click target in block coordinates; the pixel offset inside a block is irrelevant.
  logic [4:0] tgt_x;
  logic [3:0] tgt_y;
  logic       click_ok;
  logic       unused_pix_bits;

  assign tgt_x           = MOUSE_X_POS[9:5];
  assign tgt_y           = MOUSE_Y_POS[8:5];
  assign click_ok        = mouse_click && (tgt_x <= X_LAST) && (tgt_y <= Y_LAST);
  assign unused_pix_bits = ^{MOUSE_X_POS[4:0], MOUSE_Y_POS[4:0]};

  // State, cursor, ack-wait counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      x_q           <= '0;
      y_q           <= '0;
      cnt_q         <= '0;
      editing_q     <= 1'b0;
      clear_req_q   <= 1'b0;
      wr_req_q      <= 1'b0;
      wr_addr_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop captures pre-edge values.
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      cnt_q         <= cnt_d;
      editing_q     <= editing_d;
      clear_req_q   <= clear_req_d;
      wr_req_q      <= wr_req_d;
      wr_addr_q     <= wr_addr_d;
      timeout_err_q <= timeout_d;
    end
  end

  // Next state, cursor update and ack timeout.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    timeout_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (click_ok) begin
          x_d     = tgt_x;
          y_d     = tgt_y;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        // An ack on the timeout cycle wins over the timeout.
        if (canvas_clear_ack) begin
          state_d = S_EDIT;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
        end
      end
      S_EDIT: begin
        // Cancel beats commit beats a new click.
        if (key_cancel) begin
          state_d = S_IDLE;
        end else if (key_commit) begin
          state_d = S_WRITE;
        end else if (click_ok) begin
          x_d     = tgt_x;
          y_d     = tgt_y;
          state_d = S_CLEAR;
        end
      end
      S_WRITE: begin
        if (word_wr_ack) begin
          state_d = S_ADVANCE;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
        end
      end
      S_ADVANCE: begin
        state_d = S_CLEAR;
        if (x_q == X_LAST) begin
          x_d = '0;
          y_d = (y_q == Y_LAST) ? '0 : y_q + 4'd1;
        end else begin
          x_d = x_q + 5'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Counter restarts whenever a new state is entered and runs only while waiting.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if ((state_q == S_CLEAR) || (state_q == S_WRITE)) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Output values for the coming cycle, decoded from the next state.
  always_comb begin
    editing_d   = (state_d == S_EDIT);
    clear_req_d = (state_d == S_CLEAR);
    wr_req_d    = (state_d == S_WRITE);
    wr_addr_d   = wr_req_d ? {y_d, x_d} : '0;
  end

  assign editing           = editing_q;
  assign writing_block_pos = {y_q, x_q};
  assign canvas_clear_req  = clear_req_q;
  assign word_wr_req       = wr_req_q;
  assign word_wr_addr      = wr_addr_q;
  assign timeout_err       = timeout_err_q;

endmodule

// File: tb/tb_edit_block_ctrl.sv
// Self-checking bench for edit_block_ctrl: directed scenarios followed by random
// traffic, every cycle compared against a block-index based reference model.
module tb_edit_block_ctrl;

  localparam int GW   = 20;
  localparam int GH   = 15;
  localparam int TO   = 8;
  localparam int NBLK = GW * GH;

  logic       clk = 1'b0;
  logic       rst;
  logic       mouse_click;
  logic [9:0] mx;
  logic [8:0] my;
  logic       key_commit;
  logic       key_cancel;
  logic       clr_ack;
  logic       wr_ack;
  logic       editing;
  logic [8:0] pos;
  logic       clr_req;
  logic       wr_req;
  logic [8:0] wr_addr;
  logic       terr;

  int n_checks = 0;
  int n_fail   = 0;

  edit_block_ctrl #(
    .GRID_W     (GW),
    .GRID_H     (GH),
    .ACK_TIMEOUT(TO)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .mouse_click      (mouse_click),
    .MOUSE_X_POS      (mx),
    .MOUSE_Y_POS      (my),
    .key_commit       (key_commit),
    .key_cancel       (key_cancel),
    .canvas_clear_ack (clr_ack),
    .word_wr_ack      (wr_ack),
    .editing          (editing),
    .writing_block_pos(pos),
    .canvas_clear_req (clr_req),
    .word_wr_req      (wr_req),
    .word_wr_addr     (wr_addr),
    .timeout_err      (terr)
  );

  always #5 clk = ~clk;

  // Reference model: cursor kept as a linear block number, waits counted in cycles.
  typedef enum int {M_IDLE, M_CLEAR, M_EDIT, M_WRITE, M_ADV} mode_t;
  mode_t m_mode;
  int    m_blk;
  int    m_wait;
  bit    m_terr;

  function automatic bit click_hit();
    return mouse_click && (int'(mx) / 32 < GW) && (int'(my) / 32 < GH);
  endfunction

  function automatic int click_blk();
    return (int'(my) / 32) * GW + int'(mx) / 32;
  endfunction

  function automatic logic [8:0] exp_pos();
    return {4'(m_blk / GW), 5'(m_blk % GW)};
  endfunction

  task automatic model_step();
    m_terr = 1'b0;
    if (rst) begin
      m_mode = M_IDLE;
      m_blk  = 0;
      m_wait = 0;
    end else begin
      case (m_mode)
        M_IDLE: if (click_hit()) begin
          m_blk = click_blk(); m_mode = M_CLEAR; m_wait = 0;
        end
        M_CLEAR: if (clr_ack) m_mode = M_EDIT;
          else begin
            m_wait++;
            if (m_wait == TO) begin m_mode = M_IDLE; m_terr = 1'b1; end
          end
        M_EDIT: if (key_cancel) m_mode = M_IDLE;
          else if (key_commit) begin m_mode = M_WRITE; m_wait = 0; end
          else if (click_hit()) begin m_blk = click_blk(); m_mode = M_CLEAR; m_wait = 0; end
        M_WRITE: if (wr_ack) m_mode = M_ADV;
          else begin
            m_wait++;
            if (m_wait == TO) begin m_mode = M_IDLE; m_terr = 1'b1; end
          end
        M_ADV: begin
          m_blk = (m_blk + 1) % NBLK; m_mode = M_CLEAR; m_wait = 0;
        end
        default: m_mode = M_IDLE;
      endcase
    end
  endtask

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: DUT and model consume the same inputs, outputs compared 1 ns later,
  // then the one-cycle pulses are dropped.
  task automatic tick();
    logic [8:0] ep;
    @(posedge clk);
    model_step();
    #1;
    ep = exp_pos();
    check("m_editing", 9'(editing), 9'(m_mode == M_EDIT));
    check("m_pos",     pos,         ep);
    check("m_clr_req", 9'(clr_req), 9'(m_mode == M_CLEAR));
    check("m_wr_req",  9'(wr_req),  9'(m_mode == M_WRITE));
    check("m_wr_addr", wr_addr,     (m_mode == M_WRITE) ? ep : 9'h000);
    check("m_timeout", 9'(terr),    9'(m_terr));
    mouse_click = 1'b0;
    key_commit  = 1'b0;
    key_cancel  = 1'b0;
    clr_ack     = 1'b0;
    wr_ack      = 1'b0;
  endtask

  task automatic click_at(input int x, input int y);
    mouse_click = 1'b1;
    mx          = 10'(x);
    my          = 9'(y);
    tick();
  endtask

  initial begin
    rst = 1'b1; mouse_click = 1'b0; mx = '0; my = '0;
    key_commit = 1'b0; key_cancel = 1'b0; clr_ack = 1'b0; wr_ack = 1'b0;
    m_mode = M_IDLE; m_blk = 0; m_wait = 0; m_terr = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_editing", 9'(editing), 9'd0);
    check("rst_pos",     pos,         9'h000);
    check("rst_clr_req", 9'(clr_req), 9'd0);
    check("rst_wr_req",  9'(wr_req),  9'd0);
    rst = 1'b0;

    // Click at (70,40) -> block (y=1,x=2), clear requested next cycle
    click_at(70, 40);
    check("click_clr_req", 9'(clr_req), 9'd1);
    check("click_pos",     pos,         9'h022);
    clr_ack = 1'b1; tick();
    check("ack_editing",   9'(editing), 9'd1);

    // Move to the last block (19,14) and commit with immediate acks
    click_at(19 * 32, 14 * 32);
    clr_ack = 1'b1; tick();
    check("last_pos", pos, 9'h1D3);
    key_commit = 1'b1; tick();
    check("commit_wr_req",  9'(wr_req), 9'd1);
    check("commit_wr_addr", wr_addr,    9'h1D3);
    wr_ack = 1'b1; tick();
    check("advance_wr_req", 9'(wr_req), 9'd0);
    tick();
    check("wrap_clr_req", 9'(clr_req), 9'd1);
    check("wrap_pos",     pos,         9'h000);
    clr_ack = 1'b1; tick();
    check("wrap_editing", 9'(editing), 9'd1);

    // Cancel and commit together: cancel wins
    key_cancel = 1'b1; key_commit = 1'b1; tick();
    check("cancel_editing", 9'(editing), 9'd0);
    check("cancel_wr_req",  9'(wr_req),  9'd0);
    tick();
    check("cancel_wr_req2", 9'(wr_req),  9'd0);
    check("cancel_pos",     pos,         9'h000);

    // Out-of-grid clicks in IDLE
    click_at(645, 100);
    check("oog_idle_x_clr", 9'(clr_req), 9'd0);
    click_at(10, 485);
    check("oog_idle_y_clr", 9'(clr_req), 9'd0);
    check("oog_idle_pos",   pos,         9'h000);

    // Out-of-grid clicks in EDIT
    click_at(100, 100);
    clr_ack = 1'b1; tick();
    click_at(645, 100);
    click_at(10, 485);
    check("oog_edit_editing", 9'(editing), 9'd1);
    check("oog_edit_pos",     pos,         9'h063);

    // Write timeout: ack never comes
    key_commit = 1'b1; tick();
    for (int i = 0; i < TO - 1; i++) begin
      tick();
      check("to_wait_req", 9'(wr_req), 9'd1);
    end
    tick();
    check("to_err",     9'(terr),    9'd1);
    check("to_wr_req",  9'(wr_req),  9'd0);
    check("to_editing", 9'(editing), 9'd0);
    check("to_pos",     pos,         9'h063);
    tick();
    check("to_err_pulse", 9'(terr), 9'd0);

    // Ack on the timeout cycle wins
    click_at(100, 100);
    clr_ack = 1'b1; tick();
    key_commit = 1'b1; tick();
    for (int i = 0; i < TO - 1; i++) tick();
    wr_ack = 1'b1; tick();
    check("late_ack_err",    9'(terr),   9'd0);
    check("late_ack_wr_req", 9'(wr_req), 9'd0);
    tick();
    check("late_ack_clr",    9'(clr_req), 9'd1);
    check("late_ack_pos",    pos,         9'h064);

    // Clear timeout
    for (int i = 0; i < TO; i++) tick();
    check("clr_to_err", 9'(terr),    9'd1);
    check("clr_to_req", 9'(clr_req), 9'd0);

    // Reset during CLEAR, then a stray ack
    click_at(300, 200);
    rst = 1'b1; tick();
    check("mid_rst_clr", 9'(clr_req), 9'd0);
    check("mid_rst_pos", pos,         9'h000);
    rst = 1'b0;
    clr_ack = 1'b1; tick();
    check("stray_ack_editing", 9'(editing), 9'd0);
    check("stray_ack_clr",     9'(clr_req), 9'd0);

    // Random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      rst         = ($urandom_range(0, 299) == 0);
      mouse_click = ($urandom_range(0, 3) == 0);
      mx          = 10'($urandom_range(0, 1023));
      my          = 9'($urandom_range(0, 511));
      key_commit  = ($urandom_range(0, 4) == 0);
      key_cancel  = ($urandom_range(0, 15) == 0);
      clr_ack     = ($urandom_range(0, 5) == 0);
      wr_ack      = ($urandom_range(0, 5) == 0);
      tick();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
